// File: rtl/pea_actor_core.sv
// Polynomial evaluation actor core: decodes commands, stores up to SLOTS
// polynomials and evaluates them with Horner's rule, one x per firing.
// The scheduler tests `enable` for a mode and then pulses `invoke`; the core
// itself fires whatever mode it is handed and signals completion on FC.
module pea_actor_core #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 32,
    parameter int MAX_DEG   = 10,
    parameter int SLOTS     = 4,
    parameter int CNT_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     command_in,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 invoke,
    input  logic [2:0]           next_mode_in,
    input  logic [CNT_W-1:0]     command_pop,
    input  logic [CNT_W-1:0]     data_pop,
    input  logic [CNT_W-1:0]     free_space_result,
    input  logic [CNT_W-1:0]     free_space_status,
    output logic                 rd_in_command,
    output logic                 rd_in_data,
    output logic                 FC,
    output logic                 wr_out,
    output logic [OUT_WIDTH-1:0] data_out_result,
    output logic [OUT_WIDTH-1:0] data_out_status,
    output logic [2:0]           mode,
    output logic [4:0]           b,
    output logic [3:0]           N,
    output logic                 enable
);

    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int NCOEF  = MAX_DEG + 1;
    localparam logic [3:0] MAX_DEG_N = 4'(MAX_DEG);

    // Scheduler-visible modes
    localparam logic [2:0] M_GET = 3'd0;
    localparam logic [2:0] M_STP = 3'd1;
    localparam logic [2:0] M_EVP = 3'd2;
    localparam logic [2:0] M_EVB = 3'd3;
    localparam logic [2:0] M_OUT = 3'd4;
    localparam logic [2:0] M_RST = 3'd5;

    // Command opcodes
    localparam logic [2:0] OP_STP = 3'd1;
    localparam logic [2:0] OP_EVP = 3'd2;
    localparam logic [2:0] OP_EVB = 3'd3;
    localparam logic [2:0] OP_RST = 3'd5;

    // Status codes carried in the status token
    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_INVALID = 2'd1;
    localparam logic [1:0] ST_RANGE   = 2'd2;
    localparam logic [1:0] ST_OPCODE  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,   // waiting for invoke
        S_CMD,    // popping the command word
        S_STP,    // popping coefficients, highest degree first
        S_EVX,    // popping x, loading the leading coefficient
        S_EVC,    // one Horner step per cycle
        S_FC,     // firing-complete pulse
        S_OUT     // pushing result/status, FC in the same cycle
    } state_t;

    state_t                       state_q, state_d;
    logic [2:0]                   mode_q, mode_d;
    logic [4:0]                   b_q, b_d;
    logic [3:0]                   n_q, n_d;
    logic [2:0]                   op_q, op_d;
    logic [SLOT_W-1:0]            slot_q, slot_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic [WIDTH-1:0]             x_q, x_d;
    logic [OUT_WIDTH-1:0]         res_q, res_d;
    logic [1:0]                   stat_q, stat_d;
    logic [OUT_WIDTH-1:0]         ores_q, ores_d;
    logic [1:0]                   ostat_q, ostat_d;
    logic [SLOTS-1:0]             valid_q, valid_d;
    logic [SLOTS-1:0][3:0]        deg_q, deg_d;
    logic                         evb_q, evb_d;

    logic [WIDTH-1:0]             coef_mem [SLOTS][NCOEF];
    logic                         coef_we;
    logic [WIDTH-1:0]             coef_top;
    logic [WIDTH-1:0]             coef_step;
    logic [CNT_W-1:0]             b_ext;
    logic                         cmd_unused;

    // Reserved command bits carry no meaning
    assign cmd_unused = ^command_in[3:2];

    // Leading coefficient of the addressed slot, and the one below the
    // current Horner index
    assign coef_top  = coef_mem[slot_q][deg_q[slot_q]];
    assign coef_step = coef_mem[slot_q][cnt_q - 4'd1];

    assign b_ext = {{(CNT_W-5){1'b0}}, b_q};

    // Enable: can the mode presented by the scheduler fire with current FIFO levels
    always_comb begin
        enable = 1'b0;
        case (next_mode_in)
            M_GET:        enable = (command_pop != '0);
            M_STP:        enable = (data_pop >= b_ext);
            M_EVP, M_EVB: enable = (data_pop != '0) || (b_q == 5'd0);
            M_OUT:        enable = (free_space_result != '0) && (free_space_status != '0);
            M_RST:        enable = 1'b1;
            default:      enable = 1'b0;
        endcase
    end

    // Next-state and firing behaviour
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        b_d     = b_q;
        n_d     = n_q;
        op_d    = op_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        res_d   = res_q;
        stat_d  = stat_q;
        ores_d  = ores_q;
        ostat_d = ostat_q;
        valid_d = valid_q;
        deg_d   = deg_q;
        evb_d   = evb_q;
        coef_we = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (invoke) begin
                    case (next_mode_in)
                        M_GET: state_d = S_CMD;
                        M_STP: begin
                            cnt_d   = n_q;
                            state_d = S_STP;
                        end
                        M_EVP, M_EVB: begin
                            evb_d  = (next_mode_in == M_EVB);
                            mode_d = M_OUT;
                            if ((next_mode_in == M_EVB) && (b_q == 5'd0)) begin
                                // Batch already exhausted: nothing to pop
                                res_d   = '0;
                                stat_d  = ST_RANGE;
                                state_d = S_FC;
                            end else begin
                                state_d = S_EVX;
                            end
                        end
                        M_OUT: begin
                            ores_d  = res_q;
                            ostat_d = stat_q;
                            mode_d  = ((op_q == OP_EVB) && (b_q != 5'd0)) ? M_EVB : M_GET;
                            state_d = S_OUT;
                        end
                        M_RST: begin
                            valid_d = '0;
                            mode_d  = M_GET;
                            state_d = S_FC;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end

            S_CMD: begin
                op_d    = command_in[15:13];
                n_d     = command_in[7:4];
                slot_d  = command_in[SLOT_W-1:0];
                state_d = S_FC;
                case (command_in[15:13])
                    OP_STP: begin
                        mode_d = M_STP;
                        b_d    = {1'b0, command_in[7:4]} + 5'd1;
                    end
                    OP_EVP: begin
                        mode_d = M_EVP;
                        b_d    = 5'd1;
                    end
                    OP_EVB: begin
                        mode_d = M_EVB;
                        b_d    = command_in[12:8];
                    end
                    OP_RST: begin
                        mode_d = M_RST;
                        b_d    = 5'd0;
                    end
                    default: begin
                        // Unknown opcode is reported through a normal output firing
                        mode_d = M_OUT;
                        b_d    = 5'd0;
                        res_d  = '0;
                        stat_d = ST_OPCODE;
                    end
                endcase
            end

            S_STP: begin
                // Out-of-range degree: tokens are still consumed but not kept
                coef_we = (n_q <= MAX_DEG_N);
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    res_d   = '0;
                    mode_d  = M_OUT;
                    state_d = S_FC;
                    if (n_q <= MAX_DEG_N) begin
                        valid_d[slot_q] = 1'b1;
                        deg_d[slot_q]   = n_q;
                        stat_d          = ST_OK;
                    end else begin
                        stat_d = ST_RANGE;
                    end
                end
            end

            S_EVX: begin
                x_d = data_in;
                if (evb_q) begin
                    b_d = b_q - 5'd1;
                end
                if (valid_q[slot_q]) begin
                    // First Horner step folded in: 0*x + c[deg]
                    res_d   = OUT_WIDTH'(coef_top);
                    cnt_d   = deg_q[slot_q];
                    stat_d  = ST_OK;
                    state_d = (deg_q[slot_q] == 4'd0) ? S_FC : S_EVC;
                end else begin
                    res_d   = '0;
                    stat_d  = ST_INVALID;
                    state_d = S_FC;
                end
            end

            S_EVC: begin
                // Unsigned, wraps modulo 2^OUT_WIDTH
                res_d = (res_q * OUT_WIDTH'(x_q)) + OUT_WIDTH'(coef_step);
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_FC;
                end
            end

            S_FC:    state_d = S_IDLE;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers; reset aborts any firing in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q  <= M_GET;
            b_q     <= '0;
            n_q     <= '0;
            op_q    <= '0;
            slot_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            stat_q  <= '0;
            ores_q  <= '0;
            ostat_q <= '0;
            valid_q <= '0;
            evb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            b_q     <= b_d;
            n_q     <= n_d;
            op_q    <= op_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            stat_q  <= stat_d;
            ores_q  <= ores_d;
            ostat_q <= ostat_d;
            valid_q <= valid_d;
            evb_q   <= evb_d;
        end
    end

    // Data-only registers: x operand and per-slot degree (guarded by valid bits)
    always_ff @(posedge clk) begin
        x_q   <= x_d;
        deg_q <= deg_d;
    end

    // Coefficient store, written one token per cycle during a store firing
    always_ff @(posedge clk) begin
        if (coef_we) begin
            coef_mem[slot_q][cnt_q] <= data_in;
        end
    end

    assign rd_in_command   = (state_q == S_CMD);
    assign rd_in_data      = (state_q == S_STP) || (state_q == S_EVX);
    assign FC              = (state_q == S_FC) || (state_q == S_OUT);
    assign wr_out          = (state_q == S_OUT);
    assign data_out_result = ores_q;
    assign data_out_status = {{(OUT_WIDTH-2){1'b0}}, ostat_q};
    assign mode            = mode_q;
    assign b               = b_q;
    assign N               = n_q;

endmodule

// File: tb/tb_pea_actor_core.sv
// Bench for pea_actor_core: FIFO models, a mode-following scheduler and a
// polynomial reference model evaluated as a power sum.
module tb_pea_actor_core;

    logic        clk;
    logic        rst;
    logic [15:0] command_in, data_in;
    logic        invoke;
    logic [2:0]  next_mode_in;
    logic [9:0]  command_pop, data_pop, free_space_result, free_space_status;
    logic        rd_in_command, rd_in_data, FC, wr_out;
    logic [31:0] data_out_result, data_out_status;
    logic [2:0]  mode;
    logic [4:0]  b;
    logic [3:0]  N;
    logic        enable;

    pea_actor_core dut (
        .clk(clk), .rst(rst),
        .command_in(command_in), .data_in(data_in),
        .invoke(invoke), .next_mode_in(next_mode_in),
        .command_pop(command_pop), .data_pop(data_pop),
        .free_space_result(free_space_result), .free_space_status(free_space_status),
        .rd_in_command(rd_in_command), .rd_in_data(rd_in_data),
        .FC(FC), .wr_out(wr_out),
        .data_out_result(data_out_result), .data_out_status(data_out_status),
        .mode(mode), .b(b), .N(N), .enable(enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External FIFOs (driven to the DUT) and the model's own copies
    logic [15:0] cq[$], dq[$], mcq[$], mdq[$];

    // Reference model state
    bit          mvalid [4];
    bit [3:0]    mdeg [4];
    bit [15:0]   mcoef [4][16];
    bit [2:0]    mmode, mop;
    bit [4:0]    mb;
    bit [3:0]    mN;
    bit [1:0]    mslot;
    bit [31:0]   mres, mstat, lastres, laststat;
    int          exp_lat;
    int          exp_wr;

    // Observations
    logic        s_rdc, s_rdd, s_fc, s_wr;
    int          wr_cnt;
    logic [31:0] cap_res, cap_stat;
    logic [31:0] res_log[$];

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic update_heads();
        command_in  = (cq.size() > 0) ? cq[0] : 16'h0;
        data_in     = (dq.size() > 0) ? dq[0] : 16'h0;
        command_pop = 10'(cq.size());
        data_pop    = 10'(dq.size());
    endtask

    task automatic push_cmd(input logic [15:0] w);
        cq.push_back(w);
        mcq.push_back(w);
        update_heads();
    endtask

    task automatic push_data(input logic [15:0] w);
        dq.push_back(w);
        mdq.push_back(w);
        update_heads();
    endtask

    // One clock: sample outputs mid-cycle, then apply FIFO pops after the edge
    task automatic cycle();
        @(negedge clk);
        s_rdc = rd_in_command;
        s_rdd = rd_in_data;
        s_fc  = FC;
        s_wr  = wr_out;
        if (wr_out) begin
            wr_cnt++;
            cap_res  = data_out_result;
            cap_stat = data_out_status;
            res_log.push_back(data_out_result);
        end
        @(posedge clk);
        #1;
        if (s_rdc && cq.size() > 0) cq.delete(0);
        if (s_rdd && dq.size() > 0) dq.delete(0);
        update_heads();
    endtask

    // p(x) = sum c_i * x^i, modulo 2^32
    function automatic bit [31:0] poly(input int s, input bit [15:0] x);
        bit [31:0] acc, p;
        acc = 0;
        p   = 1;
        for (int i = 0; i <= int'(mdeg[s]); i++) begin
            acc = acc + 32'(mcoef[s][i]) * p;
            p   = p * 32'(x);
        end
        return acc;
    endfunction

    function automatic bit model_enable(input bit [2:0] m);
        case (m)
            3'd0:       return cq.size() >= 1;
            3'd1:       return dq.size() >= int'(mb);
            3'd2, 3'd3: return (dq.size() >= 1) || (mb == 0);
            3'd4:       return (free_space_result >= 1) && (free_space_status >= 1);
            3'd5:       return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic model_fire(input bit [2:0] m);
        logic [15:0] w;
        logic [15:0] t[$];
        logic [15:0] x;
        exp_wr  = 0;
        exp_lat = -1;
        case (m)
            3'd0: begin
                w = mcq.pop_front();
                mop = w[15:13]; mN = w[7:4]; mslot = w[1:0];
                exp_lat = 2;
                case (mop)
                    3'd1: begin mmode = 3'd1; mb = 5'(mN) + 5'd1; end
                    3'd2: begin mmode = 3'd2; mb = 5'd1; end
                    3'd3: begin mmode = 3'd3; mb = w[12:8]; end
                    3'd5: begin mmode = 3'd5; mb = 5'd0; end
                    default: begin mmode = 3'd4; mb = 5'd0; mres = 0; mstat = 3; end
                endcase
            end
            3'd1: begin
                for (int j = 0; j < int'(mb); j++) t.push_back(mdq.pop_front());
                exp_lat = int'(mb) + 1;
                if (mN <= 10) begin
                    for (int j = 0; j <= int'(mN); j++) mcoef[mslot][int'(mN) - j] = t[j];
                    mdeg[mslot]   = mN;
                    mvalid[mslot] = 1'b1;
                    mstat = 0;
                end else begin
                    mstat = 2;
                end
                mres  = 0;
                mmode = 3'd4;
            end
            3'd2, 3'd3: begin
                if (m == 3'd3 && mb == 0) begin
                    mres = 0; mstat = 2;
                end else begin
                    x = mdq.pop_front();
                    if (mvalid[mslot]) begin
                        mres = poly(int'(mslot), x);
                        mstat = 0;
                        exp_lat = int'(mdeg[mslot]) + 2;
                    end else begin
                        mres = 0; mstat = 1;
                    end
                    if (m == 3'd3) mb = mb - 5'd1;
                end
                mmode = 3'd4;
            end
            3'd4: begin
                exp_wr   = 1;
                exp_lat  = 1;
                lastres  = mres;
                laststat = mstat;
                mmode    = (mop == 3'd3 && mb > 0) ? 3'd3 : 3'd0;
            end
            3'd5: begin
                for (int s = 0; s < 4; s++) mvalid[s] = 1'b0;
                mmode   = 3'd0;
                exp_lat = 1;
            end
            default: ;
        endcase
    endtask

    task automatic fire(input bit [2:0] m);
        bit got;
        int lat;
        next_mode_in = m;
        #1;
        check("enable", 64'(enable), 64'(model_enable(m)));
        model_fire(m);
        wr_cnt = 0;
        invoke = 1'b1;
        cycle();
        invoke = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 64; k++) begin
            cycle();
            if (s_fc) begin got = 1'b1; lat = k; break; end
        end
        check("fc_seen", 64'(got), 64'(1));
        if (got && exp_lat >= 0) check("latency", 64'(lat), 64'(exp_lat));
        check("wr_count", 64'(wr_cnt), 64'(exp_wr));
        if (exp_wr == 1) begin
            check("result", 64'(cap_res), 64'(mres));
            check("status", 64'(cap_stat), 64'(mstat));
        end
        check("mode", 64'(mode), 64'(mmode));
        check("b", 64'(b), 64'(mb));
        check("N", 64'(N), 64'(mN));
        check("dout_res_hold", 64'(data_out_result), 64'(lastres));
        check("dout_stat_hold", 64'(data_out_status), 64'(laststat));
        check("cmd_fifo_level", 64'(cq.size()), 64'(mcq.size()));
        check("data_fifo_level", 64'(dq.size()), 64'(mdq.size()));
    endtask

    // Fetch one command and follow the mode sequence back to GET_COMMAND
    task automatic run(input logic [15:0] w);
        push_cmd(w);
        fire(3'd0);
        for (int g = 0; g < 16 && mmode != 3'd0; g++) fire(mmode);
    endtask

    initial begin
        int sz;
        rst = 1'b0;
        invoke = 1'b0;
        next_mode_in = 3'd0;
        free_space_result = 10'd1;
        free_space_status = 10'd1;
        update_heads();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_cmd", 64'(rd_in_command), 64'(0));
        check("rst_rd_data", 64'(rd_in_data), 64'(0));
        check("rst_fc", 64'(FC), 64'(0));
        check("rst_wr", 64'(wr_out), 64'(0));
        check("rst_mode", 64'(mode), 64'(0));
        check("rst_b", 64'(b), 64'(0));
        check("rst_N", 64'(N), 64'(0));
        check("rst_res", 64'(data_out_result), 64'(0));
        check("rst_stat", 64'(data_out_status), 64'(0));
        rst = 1'b1;

        // Store 1x^2+2x+3 in slot 0, evaluate at 2
        push_data(16'd1); push_data(16'd2); push_data(16'd3);
        run(16'h2020);
        check("tp_stp_status", 64'(cap_stat), 64'(0));
        push_data(16'd2);
        run(16'h4000);
        check("tp_evp_result", 64'(cap_res), 64'(11));

        // Batch of three on slot 0
        push_data(16'd0); push_data(16'd1); push_data(16'd3);
        res_log.delete();
        run(16'h6300);
        check("tp_evb_outputs", 64'(res_log.size()), 64'(3));
        if (res_log.size() == 3) begin
            check("tp_evb_r0", 64'(res_log[0]), 64'(3));
            check("tp_evb_r1", 64'(res_log[1]), 64'(6));
            check("tp_evb_r2", 64'(res_log[2]), 64'(18));
        end

        // Unset slot
        push_data(16'd5);
        sz = dq.size();
        run(16'h4001);
        check("tp_invalid_status", 64'(cap_stat), 64'(1));
        check("tp_invalid_pop", 64'(data_pop), 64'(sz - 1));

        // Degree out of range leaves slot 0 intact
        for (int j = 0; j < 16; j++) push_data(16'(j + 100));
        run(16'h20F0);
        check("tp_range_status", 64'(cap_stat), 64'(2));
        push_data(16'd2);
        run(16'h4000);
        check("tp_slot_kept", 64'(cap_res), 64'(11));

        // Clear all slots, then unknown opcode with a token waiting
        run(16'hA000);
        push_data(16'd2);
        run(16'h4000);
        check("tp_after_rst", 64'(cap_stat), 64'(1));
        push_data(16'h1234);
        sz = dq.size();
        run(16'hE000);
        check("tp_badop_status", 64'(cap_stat), 64'(3));
        check("tp_badop_nopop", 64'(data_pop), 64'(sz));

        // OUTPUT blocked by a full result FIFO
        push_cmd(16'h4000);
        fire(3'd0);
        fire(3'd2);
        free_space_result = 10'd0;
        next_mode_in = 3'd4;
        #1;
        check("en_out_full", 64'(enable), 64'(model_enable(3'd4)));
        free_space_result = 10'd1;
        fire(3'd4);

        // STP N=2 with only two tokens available
        push_cmd(16'h2021);
        fire(3'd0);
        push_data(16'd7); push_data(16'd8);
        next_mode_in = 3'd1;
        #1;
        check("en_stp_short", 64'(enable), 64'(model_enable(3'd1)));
        push_data(16'd9);
        fire(3'd1);
        fire(3'd4);

        // Randomized command stream
        for (int n = 0; n < 40; n++) begin
            int r;
            logic [15:0] w;
            logic [3:0] nn;
            logic [1:0] sl;
            logic [4:0] cnt;
            logic [2:0] op;
            r  = int'($urandom_range(0, 9));
            sl = 2'($urandom_range(0, 3));
            nn = 4'($urandom_range(0, 12));
            free_space_result = 10'($urandom_range(1, 5));
            free_space_status = 10'($urandom_range(1, 5));
            case (r)
                0, 1, 2, 3: begin
                    w = {3'd1, 5'($urandom), nn, 2'($urandom), sl};
                    for (int j = 0; j <= int'(nn); j++) push_data(16'($urandom));
                end
                4, 5: begin
                    w = {3'd2, 5'($urandom), nn, 2'($urandom), sl};
                    push_data(16'($urandom));
                end
                6, 7: begin
                    cnt = 5'($urandom_range(0, 3));
                    w = {3'd3, cnt, nn, 2'($urandom), sl};
                    for (int j = 0; j < int'(cnt); j++) push_data(16'($urandom));
                end
                8: w = {3'd5, 13'($urandom)};
                default: begin
                    case ($urandom_range(0, 3))
                        0: op = 3'd0;
                        1: op = 3'd4;
                        2: op = 3'd6;
                        default: op = 3'd7;
                    endcase
                    w = {op, 13'($urandom)};
                end
            endcase
            run(w);
        end
        free_space_result = 10'd1;
        free_space_status = 10'd1;

        // Reset in the middle of a long evaluation
        for (int j = 0; j < 9; j++) push_data(16'(j + 1));
        run(16'h2082);
        push_data(16'd3);
        push_cmd(16'h4002);
        fire(3'd0);
        next_mode_in = 3'd2;
        invoke = 1'b1;
        cycle();
        invoke = 1'b0;
        cycle(); cycle(); cycle();
        void'(mdq.pop_front());
        rst = 1'b0;
        #1;
        check("midrst_fc", 64'(FC), 64'(0));
        check("midrst_wr", 64'(wr_out), 64'(0));
        check("midrst_mode", 64'(mode), 64'(0));
        check("midrst_b", 64'(b), 64'(0));
        check("midrst_N", 64'(N), 64'(0));
        check("midrst_res", 64'(data_out_result), 64'(0));
        for (int s = 0; s < 4; s++) mvalid[s] = 1'b0;
        mmode = 3'd0; mb = 5'd0; mN = 4'd0; mop = 3'd0;
        mres = 0; mstat = 0; lastres = 0; laststat = 0;
        cycle(); cycle();
        rst = 1'b1;
        check("midrst_data_level", 64'(dq.size()), 64'(mdq.size()));
        push_data(16'd7);
        run(16'h4002);
        check("midrst_slot_cleared", 64'(cap_stat), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pea_actor_core.md
Name: pea_actor_core

Overview:
- Polynomial Evaluation Accelerator actor core: a CFDF-style actor with combined invoke and enable logic.
- Pops 16-bit command and data tokens from two external input FIFOs.
- Stores up to 4 polynomials and evaluates them with Horner's method.
- Pushes one 32-bit result token and one 32-bit status token per output firing into two external depth-1 output FIFOs. An external scheduler supplies the mode to fire and pulses invoke.

Parameters:
WIDTH, 16, input token width (command and data)
OUT_WIDTH, 32, result/status token width
MAX_DEG, 10, highest legal polynomial degree
SLOTS, 4, number of stored polynomials
CNT_W, 10, width of the FIFO population/free-space inputs

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
command_in  in  WIDTH  head token of command FIFO (first-word fall-through)
data_in  in  WIDTH  head token of data FIFO (first-word fall-through)
invoke  in  1  one-cycle pulse starting a firing in mode next_mode_in
next_mode_in  in  3  mode to fire / to test for enable
command_pop  in  CNT_W  command FIFO population
data_pop  in  CNT_W  data FIFO population
free_space_result  in  CNT_W  result FIFO free space
free_space_status  in  CNT_W  status FIFO free space
rd_in_command  out  1  pop command FIFO; head sampled in the same cycle
rd_in_data  out  1  pop data FIFO; head sampled in the same cycle
FC  out  1  one-cycle firing-complete pulse
wr_out  out  1  push data_out_result and data_out_status together
data_out_result  out  OUT_WIDTH  result token
data_out_status  out  OUT_WIDTH  status token
mode  out  3  next mode the scheduler must fire
b  out  5  data tokens required by the next compute firing
N  out  4  degree field of the current command
enable  out  1  combinational: next_mode_in can fire now

Behaviour:
- Modes: GET_COMMAND=0, STP=1, EVP=2, EVB=3, OUTPUT=4, RST=5. Values 6 and 7 give enable=0.
- Command word fields:
  - [15:13] opcode: 1=STP, 2=EVP, 3=EVB, 5=RST.
  - [12:8] EVB count.
  - [7:4] N.
  - [3:2] reserved, ignored.
  - [1:0] slot.
- Reset (rst=0, async):
  - All outputs 0; mode=GET_COMMAND; b=0; N=0.
  - All slot-valid bits cleared; internal state idle.
- enable (combinational):
  - GET_COMMAND: command_pop>=1.
  - STP: data_pop>=b.
  - EVP/EVB: data_pop>=1, or b=0.
  - OUTPUT: both free-space inputs >=1.
  - RST: always 1.
- The core never checks enable. invoke while a firing is in progress is ignored.
- GET_COMMAND firing:
  - Pulse rd_in_command for 1 cycle and latch the word.
  - N = [7:4]. b = N+1 for STP, 1 for EVP, count for EVB, 0 otherwise.
  - FC is asserted the next cycle.
  - mode becomes the opcode's mode. Unknown opcode goes to OUTPUT with status 3, result 0.
- STP firing:
  - Pop b tokens, one per cycle: first token is the highest-degree coefficient, last is the constant term.
  - If N<=MAX_DEG: store the coefficients and N in the slot, set slot valid, status 0.
  - Otherwise: discard the tokens, leave the slot unchanged, status 2.
  - FC after the last pop. mode=OUTPUT. result=0.
- EVP/EVB firing (one x per firing):
  - Pop x (1 cycle), then acc starts at 0 and runs acc = acc*x + c[i] for i from the highest degree down.
  - One step per cycle; everything is unsigned and wraps modulo 2^32.
  - Latency: N_slot+2 cycles from invoke to FC.
  - Invalid slot: x still popped, result 0, status 1.
  - EVB count=0: no pop, status 2, result 0.
  - After each EVB firing, b is decremented. mode=OUTPUT.
- OUTPUT firing:
  - Drive result/status and pulse wr_out for 1 cycle, with FC in the same cycle.
  - mode = EVB if the command is EVB and b>0, otherwise GET_COMMAND.
- RST firing: clear all slot-valid bits; FC next cycle; no output; mode=GET_COMMAND.
- Outputs data_out_* hold their values until the next OUTPUT firing.
- Reset mid-firing aborts immediately. Any partially popped tokens are lost.

Test Plan:
- STP 0x2020 with data 1,2,3 -> status 0, result 0. Then EVP 0x4000 with x=2 -> result 11, status 0. Each wr_out pulses once.
- EVB 0x6300 on slot 0 with x=0,1,3 -> three OUTPUT firings with results 3,6,18, status 0. mode returns to GET_COMMAND after the third.
- EVP 0x4001 (slot 1 never set) with x=5 -> result 0, status 1; data_pop decrements by 1.
- STP 0x20F0 (N=15) with 16 data tokens -> status 2; slot 0 unchanged, so a following EVP x=2 still gives 11.
- RST 0xA000, then EVP 0x4000 x=2 -> status 1. Opcode 0xE000 -> status 3, no data popped.
- Enable checks:
  - OUTPUT with free_space_result=0 -> enable=0.
  - STP N=2 with data_pop=2 -> enable=0.
  - Reset asserted mid-EVP -> FC=0, wr_out=0, mode=GET_COMMAND.
